multicycle_mem_responder: RTL and testbench

Unified instruction/data memory that serves the multicycle RISC-V datapath. It is the responder end of the control FSM's memory interface.
- Samples mem_read / mem_write with the already-muxed address (i_or_d applied upstream).
- Performs the access after a programmable latency.
- Signals completion with a one-cycle mem_ready pulse, so the control FSM can stall in fetch/memory states.

---
 rtl/multicycle_mem_responder.sv | 138 +++++++++++++
 tb/tb_multicycle_mem_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mem_responder.sv
// Unified I/D memory responder for the multicycle core; fixed-latency access with ready/err pulses.
// Optional MEM_ACCESS_COUNT_EN adds read/write commit counters.
module multicycle_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 16384,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  mem_ready,
  output logic                  mem_err
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
`endif
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  commit;
  logic                  addr_unused;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Upper address bits only alias; accesses wrap modulo MEM_DEPTH.
  assign addr_unused = ^addr[DATA_WIDTH-1:AW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          if ((mem_read && mem_write) || (addr[1:0] != 2'b00)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_INIT;
            we_d    = mem_write;
            idx_d   = addr[AW+1:2];
            wdat_d  = din;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdat_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      if (commit && !we_q) begin
        dout_q <= mem[idx_q];
      end
    end
  end

  // Array is never reset; reset during BUSY suppresses the commit.
  always_ff @(posedge clk) begin
    if (!reset && commit && we_q) begin
      mem[idx_q] <= wdat_q;
    end
  end

  assign dout      = dout_q;
  assign mem_ready = (state_q == S_DONE);
  assign mem_err   = (state_q == S_ERR);

`ifdef MEM_ACCESS_COUNT_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (commit) begin
      if (we_q) wr_count_d = wr_count_q + 32'd1;
      else      rd_count_d = rd_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Directed bench for multicycle_mem_responder: vector table plus
// hand sequences for held requests and reset abort.
module tb_multicycle_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        mem_ready;
  logic        mem_err;
`ifdef MEM_ACCESS_COUNT_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  int tests = 0;
  int fails = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic both_seen = 1'b0;

  multicycle_mem_responder #(
    .DATA_WIDTH(32),
    .MEM_DEPTH (DEPTH),
    .LATENCY   (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .addr     (addr),
    .din      (din),
    .dout     (dout),
    .mem_ready(mem_ready),
    .mem_err  (mem_err)
`ifdef MEM_ACCESS_COUNT_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_err;
    logic        chk_dout;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive a request, count edges until ready/err, then drop it.
  task automatic run_req(input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic err);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    din       = d;
    lat       = -1;
    err       = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (mem_ready && mem_err) both_seen = 1'b1;
      if (mem_ready || mem_err) begin
        lat = i;
        err = mem_err;
        break;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk); #1;
    if (lat > 0 && !err) begin
      if (wr) exp_wr++;
      else    exp_rd++;
    end
  endtask

  initial begin
    int          lat;
    logic        err;
    int          pulses;
    logic        prev_pulse;
    logic        gap_bad;
    logic        dout_bad;
    logic        late_ready;

    vecs.push_back('{"wr10",   0, 1, 32'h10,   32'hDEADBEEF, 0, 0, 32'h0});
    vecs.push_back('{"rd10",   1, 0, 32'h10,   32'h0,        0, 1, 32'hDEADBEEF});
    vecs.push_back('{"wr20",   0, 1, 32'h20,   32'h12345678, 0, 1, 32'hDEADBEEF});
    vecs.push_back('{"both20", 1, 1, 32'h20,   32'hFFFFFFFF, 1, 1, 32'hDEADBEEF});
    vecs.push_back('{"rd20",   1, 0, 32'h20,   32'h0,        0, 1, 32'h12345678});
    vecs.push_back('{"wr14",   0, 1, 32'h14,   32'hA5A5A5A5, 0, 1, 32'h12345678});
    vecs.push_back('{"rd10b",  1, 0, 32'h10,   32'h0,        0, 1, 32'hDEADBEEF});
    vecs.push_back('{"rd14",   1, 0, 32'h14,   32'h0,        0, 1, 32'hA5A5A5A5});
    vecs.push_back('{"mis6",   1, 0, 32'h6,    32'h0,        1, 1, 32'hA5A5A5A5});
    vecs.push_back('{"misw2",  0, 1, 32'h22,   32'h0,        1, 1, 32'hA5A5A5A5});
    vecs.push_back('{"rd20b",  1, 0, 32'h20,   32'h0,        0, 1, 32'h12345678});
    vecs.push_back('{"wrwrap", 0, 1, DEPTH*4+4, 32'h55,      0, 1, 32'h12345678});
    vecs.push_back('{"rd4",    1, 0, 32'h4,    32'h0,        0, 1, 32'h55});

    reset     = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = '0;
    din       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout",  dout, 32'h0);
    chk("rst_ready", {31'b0, mem_ready}, 32'h0);
    chk("rst_err",   {31'b0, mem_err}, 32'h0);
`ifdef MEM_ACCESS_COUNT_EN
    chk("rst_rdcnt", rd_count, 32'h0);
    chk("rst_wrcnt", wr_count, 32'h0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", {31'b0, mem_ready}, 32'h0);

    for (int v = 0; v < vecs.size(); v++) begin
      run_req(vecs[v].rd, vecs[v].wr, vecs[v].a, vecs[v].d, lat, err);
      chk({vecs[v].name, "_lat"}, lat, vecs[v].exp_err ? 1 : LAT + 1);
      chk({vecs[v].name, "_err"}, {31'b0, err}, {31'b0, vecs[v].exp_err});
      if (vecs[v].chk_dout)
        chk({vecs[v].name, "_dout"}, dout, vecs[v].exp_dout);
    end

    // Read held high: one pulse per accepted request, idle gap after each.
    run_req(1'b1, 1'b0, 32'h10, 32'h0, lat, err);
    chk("pre_hold_dout", dout, 32'hDEADBEEF);
    mem_read   = 1'b1;
    addr       = 32'h10;
    pulses     = 0;
    prev_pulse = 1'b0;
    gap_bad    = 1'b0;
    dout_bad   = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      if (i == 10) mem_read = 1'b0;
      if (mem_ready && mem_err) both_seen = 1'b1;
      if (prev_pulse && (mem_ready || mem_err)) gap_bad = 1'b1;
      if (mem_err) gap_bad = 1'b1;
      if (dout !== 32'hDEADBEEF) dout_bad = 1'b1;
      if (mem_ready) pulses++;
      prev_pulse = mem_ready;
    end
    exp_rd += pulses;
    chk("hold_pulses", pulses, 3);
    chk("hold_gap",    {31'b0, gap_bad}, 32'h0);
    chk("hold_dout",   {31'b0, dout_bad}, 32'h0);

`ifdef MEM_ACCESS_COUNT_EN
    chk("cnt_rd", rd_count, exp_rd);
    chk("cnt_wr", wr_count, exp_wr);
`endif

    // Reset in the second BUSY cycle aborts a pending write.
    run_req(1'b0, 1'b1, 32'h30, 32'h0, lat, err);
    chk("pre30_lat", lat, LAT + 1);
    mem_write = 1'b1;
    addr      = 32'h30;
    din       = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    chk("abort_ready", {31'b0, mem_ready}, 32'h0);
    chk("abort_err",   {31'b0, mem_err}, 32'h0);
    chk("abort_dout",  dout, 32'h0);
    late_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (mem_ready || mem_err) late_ready = 1'b1;
    end
    chk("abort_nopulse", {31'b0, late_ready}, 32'h0);
    run_req(1'b1, 1'b0, 32'h30, 32'h0, lat, err);
    chk("rd30_lat",  lat, LAT + 1);
    chk("rd30_dout", dout, 32'h0);

`ifdef MEM_ACCESS_COUNT_EN
    chk("cnt2_rd", rd_count, exp_rd);
    chk("cnt2_wr", wr_count, exp_wr);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("cnt3_rd", rd_count, 32'h0);
    chk("cnt3_wr", wr_count, 32'h0);
`endif

    chk("never_both", {31'b0, both_seen}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
